keycode_action_ctrl: RTL and testbench

//  Sits directly downstream of the SoC keycode PIO (8-bit USB HID keycode written by the NIOS).

---
 rtl/keycode_action_ctrl_pkg.sv | 17 +
 rtl/keycode_action_ctrl_if.sv | 25 ++
 rtl/keycode_action_ctrl_cooldown.sv | 32 +++
 rtl/keycode_action_ctrl.sv | 155 +++++++++++++++
 tb/tb_keycode_action_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/keycode_action_ctrl_pkg.sv
// Keycode constants and jump state encoding shared by the keycode action controller.
package hk_input_pkg;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_J     = 8'h0D;
    localparam logic [7:0] KC_K     = 8'h0E;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUF      = 2'd1,
        WAIT_REL = 2'd2
    } jump_state_t;

endpackage

// File: rtl/keycode_action_ctrl_if.sv
// Keycode in, per-frame player actions out; master drives keys/frame/ack, slave is the controller.
interface keycode_action_ctrl_if;

    logic [7:0] keycode;
    logic       frame_clk;
    logic       jump_ack;
    logic       move_left;
    logic       move_right;
    logic       facing_left;
    logic       jump_held;
    logic       jump_req;
    logic       attack_pulse;
    logic       dash_pulse;

    modport master (
        output keycode, frame_clk, jump_ack,
        input  move_left, move_right, facing_left, jump_held, jump_req, attack_pulse, dash_pulse
    );

    modport slave (
        input  keycode, frame_clk, jump_ack,
        output move_left, move_right, facing_left, jump_held, jump_req, attack_pulse, dash_pulse
    );

endinterface

// File: rtl/keycode_action_ctrl_cooldown.sv
// One-frame action pulse with a frame-counted cooldown; presses during cooldown are dropped.
module key_pulse_cooldown #(
    parameter int CD = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_tick,
    input  logic press,
    output logic pulse
);

    localparam int CW = $clog2(CD + 1);

    logic [CW-1:0] cd_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pulse  <= 1'b0;
            cd_cnt <= '0;
        end else if (frame_tick) begin
            if (press && (cd_cnt == '0)) begin
                pulse  <= 1'b1;
                cd_cnt <= CW'(CD);
            end else begin
                pulse <= 1'b0;
                if (cd_cnt != '0)
                    cd_cnt <= cd_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/keycode_action_ctrl.sv
// Filters the PIO keycode and turns it into frame-synchronous knight actions.
//  state    | meaning
//  IDLE     | no jump outstanding; a Space press seen at a frame tick starts one
//  BUF      | jump_req high, waiting for jump_ack or the buffer to run out
//  WAIT_REL | request done; Space must be released before another can start
module keycode_action_ctrl
    import hk_input_pkg::*;
#(
    parameter int FILTER_CYC = 4,
    parameter int JUMP_BUF   = 6,
    parameter int ATK_CD     = 20,
    parameter int DASH_CD    = 40
) (
    input logic                 Clk,
    input logic                 Reset,
    keycode_action_ctrl_if.slave bus
);

    localparam int FW = $clog2(FILTER_CYC + 1);
    localparam int BW = $clog2(JUMP_BUF + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYC - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUF  = BUF;
    localparam logic [1:0] ST_WAIT = WAIT_REL;

    logic          fs1, fs2, fs3;
    logic          frame_tick;
    logic [7:0]    key_prev;
    logic [7:0]    key_stable;
    logic [FW-1:0] filt_cnt;
    logic          key_load;
    logic          flag_space, flag_atk, flag_dash;
    logic [1:0]    jump_state;
    logic [BW-1:0] buf_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1 <= 1'b0;
            fs2 <= 1'b0;
            fs3 <= 1'b0;
        end else begin
            fs1 <= bus.frame_clk;
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end

    assign frame_tick = fs2 & ~fs3;

    // Only a real change of the accepted key counts as a press.
    assign key_load = (bus.keycode == key_prev) && (filt_cnt == FILT_LAST)
                      && (bus.keycode != key_stable);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_prev   <= KC_NONE;
            key_stable <= KC_NONE;
            filt_cnt   <= '0;
        end else begin
            key_prev <= bus.keycode;
            if (bus.keycode != key_prev)
                filt_cnt <= '0;
            else if (filt_cnt != FILT_LAST)
                filt_cnt <= filt_cnt + 1'b1;
            if (key_load)
                key_stable <= bus.keycode;
        end
    end

    // A press landing on the tick cycle survives into the next frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flag_space <= 1'b0;
            flag_atk   <= 1'b0;
            flag_dash  <= 1'b0;
        end else begin
            flag_space <= (key_load && bus.keycode == KC_SPACE) | (flag_space & ~frame_tick);
            flag_atk   <= (key_load && bus.keycode == KC_J)     | (flag_atk   & ~frame_tick);
            flag_dash  <= (key_load && bus.keycode == KC_K)     | (flag_dash  & ~frame_tick);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.move_left   <= 1'b0;
            bus.move_right  <= 1'b0;
            bus.jump_held   <= 1'b0;
            bus.facing_left <= 1'b0;
        end else if (frame_tick) begin
            bus.move_left  <= (key_stable == KC_A);
            bus.move_right <= (key_stable == KC_D);
            bus.jump_held  <= (key_stable == KC_SPACE);
            if (key_stable == KC_A)
                bus.facing_left <= 1'b1;
            else if (key_stable == KC_D)
                bus.facing_left <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            jump_state   <= ST_IDLE;
            buf_cnt      <= '0;
            bus.jump_req <= 1'b0;
        end else begin
            case (jump_state)
                ST_IDLE: begin
                    if (frame_tick && flag_space) begin
                        jump_state   <= ST_BUF;
                        buf_cnt      <= BW'(JUMP_BUF);
                        bus.jump_req <= 1'b1;
                    end
                end
                ST_BUF: begin
                    if (bus.jump_ack) begin
                        jump_state   <= ST_WAIT;
                        buf_cnt      <= '0;
                        bus.jump_req <= 1'b0;
                    end else if (frame_tick) begin
                        if (buf_cnt > BW'(1)) begin
                            buf_cnt <= buf_cnt - 1'b1;
                        end else begin
                            buf_cnt      <= '0;
                            bus.jump_req <= 1'b0;
                            jump_state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (key_stable != KC_SPACE)
                        jump_state <= ST_IDLE;
                end
                default: jump_state <= ST_IDLE;
            endcase
        end
    end

    key_pulse_cooldown #(.CD(ATK_CD)) u_attack (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .press      (flag_atk),
        .pulse      (bus.attack_pulse)
    );

    key_pulse_cooldown #(.CD(DASH_CD)) u_dash (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .press      (flag_dash),
        .pulse      (bus.dash_pulse)
    );

endmodule

// File: tb/tb_keycode_action_ctrl.sv
// Frame-level bench for keycode_action_ctrl: directed scenarios, then random key traffic vs a frame model.
module tb_keycode_action_ctrl;
    import hk_input_pkg::*;

    localparam int JUMP_BUF = 6;
    localparam int ATK_CD   = 20;
    localparam int DASH_CD  = 40;

    logic clk_sys = 1'b0;
    logic reset;

    always #10 clk_sys = ~clk_sys;

    keycode_action_ctrl_if bus ();

    keycode_action_ctrl #(
        .FILTER_CYC (4),
        .JUMP_BUF   (JUMP_BUF),
        .ATK_CD     (ATK_CD),
        .DASH_CD    (DASH_CD)
    ) dut (
        .Clk   (clk_sys),
        .Reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // frame-level model: accepted key, jump request bookkeeping by frame number, last pulse frames
    logic [7:0] m_stable;
    bit         m_facing, m_pending, m_wait;
    bit         f_space, f_atk, f_dash;
    int         m_frame = 0;
    int         m_req_frame, m_last_atk, m_last_dash;

    logic [7:0] key_tbl [8];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (frame %0d)", tag, obs, exp, m_frame);
        end
    endtask

    task automatic model_reset();
        m_stable    = KC_NONE;
        m_facing    = 1'b0;
        m_pending   = 1'b0;
        m_wait      = 1'b0;
        f_space     = 1'b0;
        f_atk       = 1'b0;
        f_dash      = 1'b0;
        m_last_atk  = -1000;
        m_last_dash = -1000;
    endtask

    task automatic model_seg(input logic [7:0] k);
        if (k != m_stable) begin
            if (k == KC_SPACE) f_space = 1'b1;
            if (k == KC_J)     f_atk   = 1'b1;
            if (k == KC_K)     f_dash  = 1'b1;
        end
        m_stable = k;
        if (m_wait && k != KC_SPACE) m_wait = 1'b0;
    endtask

    task automatic model_tick(output bit atk, output bit dash);
        m_frame++;
        if (m_pending) begin
            if (m_frame - m_req_frame >= JUMP_BUF) begin
                m_pending = 1'b0;
                m_wait    = (m_stable == KC_SPACE);
            end
        end else if (!m_wait && f_space) begin
            m_pending   = 1'b1;
            m_req_frame = m_frame;
        end
        atk  = f_atk  && (m_frame - m_last_atk  > ATK_CD);
        dash = f_dash && (m_frame - m_last_dash > DASH_CD);
        if (atk)  m_last_atk  = m_frame;
        if (dash) m_last_dash = m_frame;
        if (m_stable == KC_A) m_facing = 1'b1;
        else if (m_stable == KC_D) m_facing = 1'b0;
        f_space = 1'b0;
        f_atk   = 1'b0;
        f_dash  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        reset         = 1'b1;
        bus.keycode   = KC_NONE;
        bus.frame_clk = 1'b0;
        bus.jump_ack  = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_move_left",   int'(bus.move_left),    0);
        chk("rst_move_right",  int'(bus.move_right),   0);
        chk("rst_facing_left", int'(bus.facing_left),  0);
        chk("rst_jump_held",   int'(bus.jump_held),    0);
        chk("rst_jump_req",    int'(bus.jump_req),     0);
        chk("rst_attack",      int'(bus.attack_pulse), 0);
        chk("rst_dash",        int'(bus.dash_pulse),   0);
        reset = 1'b0;
        model_reset();
    endtask

    // One frame: optional ack, up to three qualified key segments, optional short glitch, then the tick.
    task automatic do_frame(input int nseg, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input bit ack, input int glitch_len,
                            input logic [7:0] glitch_code);
        logic [7:0] seg [3];
        logic [7:0] held;
        bit         atk, dash;
        seg[0] = s0;
        seg[1] = s1;
        seg[2] = s2;
        if (ack) begin
            bus.jump_ack = 1'b1;
            @(negedge clk_sys);
            bus.jump_ack = 1'b0;
            if (m_pending) begin
                m_pending = 1'b0;
                m_wait    = (m_stable == KC_SPACE);
            end
            chk("jump_req_after_ack", int'(bus.jump_req), int'(m_pending));
            @(negedge clk_sys);
        end
        for (int i = 0; i < nseg; i++) begin
            bus.keycode = seg[i];
            repeat (8) @(negedge clk_sys);
            model_seg(seg[i]);
        end
        if (glitch_len > 0) begin
            held        = bus.keycode;
            bus.keycode = glitch_code;
            repeat (glitch_len) @(negedge clk_sys);
            bus.keycode = held;
        end
        repeat (8) @(negedge clk_sys);
        bus.frame_clk = 1'b1;
        repeat (4) @(negedge clk_sys);
        model_tick(atk, dash);
        chk("move_left",    int'(bus.move_left),    int'(m_stable == KC_A));
        chk("move_right",   int'(bus.move_right),   int'(m_stable == KC_D));
        chk("jump_held",    int'(bus.jump_held),    int'(m_stable == KC_SPACE));
        chk("facing_left",  int'(bus.facing_left),  int'(m_facing));
        chk("jump_req",     int'(bus.jump_req),     int'(m_pending));
        chk("attack_pulse", int'(bus.attack_pulse), int'(atk));
        chk("dash_pulse",   int'(bus.dash_pulse),   int'(dash));
        bus.frame_clk = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) do_frame(0, KC_NONE, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        key_tbl = '{KC_NONE, KC_A, KC_D, KC_SPACE, KC_J, KC_K, 8'h15, KC_SPACE};
        reset         = 1'b1;
        bus.keycode   = KC_NONE;
        bus.frame_clk = 1'b0;
        bus.jump_ack  = 1'b0;
        model_reset();
        apply_reset();

        idle_frames(1);
        do_frame(1, KC_A, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
        chk("left_move_left",   int'(bus.move_left),   1);
        chk("left_facing_left", int'(bus.facing_left), 1);
        do_frame(0, KC_NONE, KC_NONE, KC_NONE, 1'b0, 2, KC_D);
        chk("glitch_move_right", int'(bus.move_right), 0);

        // Space tap shorter than a frame, never acknowledged
        do_frame(2, KC_SPACE, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
        chk("tap_jump_req", int'(bus.jump_req), 1);
        idle_frames(5);
        chk("tap_req_last", int'(bus.jump_req), 1);
        idle_frames(1);
        chk("tap_req_expired", int'(bus.jump_req), 0);

        // Space held, acknowledged, held on, then released and re-pressed
        do_frame(1, KC_SPACE, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
        idle_frames(1);
        do_frame(0, KC_NONE, KC_NONE, KC_NONE, 1'b1, 0, KC_NONE);
        idle_frames(10);
        chk("held_no_rereq", int'(bus.jump_req), 0);
        do_frame(2, KC_NONE, KC_SPACE, KC_NONE, 1'b0, 0, KC_NONE);
        chk("repress_jump_req", int'(bus.jump_req), 1);
        do_frame(1, KC_NONE, KC_NONE, KC_NONE, 1'b1, 0, KC_NONE);
        idle_frames(ATK_CD + 2);

        // J at relative frames 1, 5 and 22
        for (int r = 1; r <= 23; r++) begin
            if (r == 1 || r == 5 || r == 22)
                do_frame(2, KC_J, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
            else
                idle_frames(1);
            if (r == 1 || r == 22) chk("atk_pulse_expected", int'(bus.attack_pulse), 1);
            if (r == 5)            chk("atk_cooldown_drop",  int'(bus.attack_pulse), 0);
        end

        // reset while a jump is pending and dash cooldown sits at 30
        do_frame(2, KC_K, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
        idle_frames(9);
        do_frame(1, KC_SPACE, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
        chk("pre_rst_jump_req", int'(bus.jump_req), 1);
        apply_reset();
        do_frame(2, KC_K, KC_NONE, KC_NONE, 1'b0, 0, KC_NONE);
        chk("dash_after_rst", int'(bus.dash_pulse), 1);

        for (int f = 0; f < 150; f++) begin
            do_frame($urandom_range(0, 3),
                     key_tbl[$urandom_range(0, 7)], key_tbl[$urandom_range(0, 7)],
                     key_tbl[$urandom_range(0, 7)],
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                     key_tbl[$urandom_range(0, 7)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
